execute_muldiv: RTL
===================

// Module: execute_muldiv
// PURPOSE
//   Iterative RV32M multiply/divide unit. It is the multi-cycle companion to the single-cycle execute ALU.
//   - Accepts one op via valid/ready and computes one bit per cycle.
//   - Holds the result with the destination-register tag until writeback accepts it.
//   - Supports flush for branch/jump squash.
//   - Generalised over XLEN. Adds handshake, back-pressure and RISC-V corner-case results.
// PARAMETERS
//   XLEN      32  operand/result width (>=8, even)
//   REG_AW    5   destination register tag width
// PORTS
//   i_clk         in   1       clock, rising edge
//   i_rst_n       in   1       synchronous reset, active low
//   i_valid       in   1       request valid
//   o_ready       out  1       unit can accept a request (state==IDLE && i_rst_n)
//   i_op          in   3       RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   i_operand1    in   XLEN    rs1 value
//   i_operand2    in   XLEN    rs2 value
//   i_rd          in   REG_AW  destination tag
//   i_flush       in   1       squash in-flight op
//   o_valid       out  1       result valid
//   i_ready       in   1       writeback accepts result
//   o_result      out  XLEN    result
//   o_rd          out  REG_AW  tag of the result
//   o_busy        out  1       state != IDLE
// BEHAVIOUR
//   Reset: state IDLE; o_valid, o_result, o_rd and o_busy are all 0; internal counter and accumulators are cleared.
//   FSM has three states: IDLE, CALC, DONE.
//   IDLE:
//     - On i_valid && o_ready, latch op, tag and operand magnitudes.
//     - Signed operands: MUL*/DIV/REM treat rs1 as signed except MULHU/DIVU/REMU. rs2 is unsigned for MULHSU/MULHU/DIVU/REMU.
//     - Record result sign, load counter = XLEN, then go to CALC.
//   Special cases skip CALC and go to DONE directly:
//     - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
//     - Signed overflow (rs1 = MIN_INT, rs2 = -1): DIV -> MIN_INT; REM -> 0.
//   CALC:
//     - Multiply: shift-add into a 2*XLEN product.
//     - Divide: restoring divide into quotient and remainder.
//     - Counter decrements each cycle. At count 1, apply the sign correction, register the result, go to DONE.
//   Sign rules:
//     - Quotient is negative iff the operand signs differ.
//     - Remainder takes the sign of the dividend.
//     - MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits of the signed product.
//   Latency:
//     - Normal op: o_valid rises XLEN+1 edges after the accepting edge.
//     - Special case: o_valid rises 1 edge after the accepting edge.
//   DONE:
//     - o_valid=1. o_result and o_rd are held stable until i_ready.
//     - On o_valid && i_ready, go to IDLE; o_valid drops and o_ready rises on the next edge.
//     - No new request is accepted in DONE (o_ready=0).
//   Flush (i_flush=1, any state): next edge -> IDLE, o_valid=0, result discarded.
//     - Flush beats a same-cycle accept: the request is not taken.
//     - Flush beats a same-cycle DONE handshake: the result is dropped.
//   Reset mid-op: same as flush, and o_result and o_rd are also cleared.
//   i_op, the operands and i_rd are ignored unless accepted. o_result is only meaningful while o_valid=1.
// TESTING (XLEN=32)
//   MUL 7 * 0xFFFFFFFD -> o_result 0xFFFFFFEB; o_valid exactly 33 edges after accept; o_rd echoes i_rd.
//   MULH 0x80000000 * 0x80000000 -> 0x40000000.
//   MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
//   DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
//   REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
//   DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
//   DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; all with o_valid 1 edge after accept.
//   Back-pressure:
//     - Hold i_ready=0 for 10 cycles after o_valid: o_result stable, o_ready=0, a pulsed i_valid is ignored.
//     - Then i_ready=1: o_ready=1 on the next cycle and a new request is accepted.
//   Flush 10 cycles into CALC -> o_valid never rises for that op, o_busy=0 next cycle.
//   Same-cycle i_valid+i_flush in IDLE -> not accepted.
//   Reset mid-CALC -> all outputs 0 next edge.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// Request/response bundle between issue, the iterative mul/div unit and writeback.
// master drives the request side and the writeback ready; slave is the unit.
interface execute_muldiv_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              i_valid;
    logic              o_ready;
    logic [2:0]        i_op;
    logic [XLEN-1:0]   i_operand1;
    logic [XLEN-1:0]   i_operand2;
    logic [REG_AW-1:0] i_rd;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [XLEN-1:0]   o_result;
    logic [REG_AW-1:0] o_rd;
    logic              o_busy;

    modport master (
        output i_valid, i_op, i_operand1, i_operand2, i_rd, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_rd, o_busy
    );

    modport slave (
        input  i_valid, i_op, i_operand1, i_operand2, i_rd, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_rd, o_busy
    );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes,
// sign fixed up on the final step, result held until writeback takes it.
module execute_muldiv #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    execute_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [2:0]          op;
    logic                neg;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     bmag;
    logic [2*XLEN-1:0]   acc;
    logic                valid_q;
    logic [XLEN-1:0]     result_q;
    logic [REG_AW-1:0]   rd_q;

    logic                is_div, is_rem, s1, s2, neg1, neg2, div0, ovf, sign;
    logic [XLEN-1:0]     mag1, mag2, spec_res;

    always_comb begin
        is_div   = bus.i_op[2];
        is_rem   = bus.i_op[2] & bus.i_op[1];
        s1       = is_div ? ~bus.i_op[0] : (bus.i_op[1:0] != 2'd3);
        s2       = is_div ? ~bus.i_op[0] : ~bus.i_op[1];
        neg1     = s1 & bus.i_operand1[XLEN-1];
        neg2     = s2 & bus.i_operand2[XLEN-1];
        mag1     = neg1 ? -bus.i_operand1 : bus.i_operand1;
        mag2     = neg2 ? -bus.i_operand2 : bus.i_operand2;
        sign     = is_rem ? neg1 : (neg1 ^ neg2);
        div0     = is_div && (bus.i_operand2 == '0);
        ovf      = is_div && s1 && (bus.i_operand1 == MIN_INT)
                   && (bus.i_operand2 == '1);
        spec_res = div0 ? (is_rem ? bus.i_operand1 : '1)
                        : (is_rem ? '0 : MIN_INT);
    end

    // acc is {product-high, multiplier} for MUL*, {remainder, quotient} for DIV*
    logic [XLEN:0]       mul_sum, trial;
    logic [2*XLEN-1:0]   nxt, fin;
    logic [XLEN-1:0]     dres, calc_res;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bmag} : '0);
        trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, bmag};
        if (op[2])
            nxt = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            nxt = {mul_sum, acc[XLEN-1:1]};
        fin  = neg ? -nxt : nxt;
        dres = op[1] ? nxt[2*XLEN-1:XLEN] : nxt[XLEN-1:0];
        if (op[2])
            calc_res = neg ? -dres : dres;
        else
            calc_res = (op[1:0] == 2'd0) ? fin[XLEN-1:0] : fin[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op       <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            bmag     <= '0;
            acc      <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else if (bus.i_flush) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.i_valid) begin
                    op   <= bus.i_op;
                    rd_q <= bus.i_rd;
                    if (div0 || ovf) begin
                        result_q <= spec_res;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, mag1};
                        bmag  <= mag2;
                        neg   <= sign;
                        cnt   <= CW'(XLEN);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result_q <= calc_res;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: if (bus.i_ready) begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready  = (state == IDLE) && i_rst_n;
    assign bus.o_busy   = (state != IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_rd     = rd_q;
endmodule
